// File: rtl/output_buf_pkg.sv
// Shared constants, per-layer word table and FSM encoding for the output-buffer read stage.
package output_buf_pkg;

  localparam int unsigned DEF_PART_SIZE  = 1024;
  localparam int unsigned PARTS_PER_BANK = 4;
  localparam int unsigned BANK0_BASE     = 0;
  localparam int unsigned BANK1_BASE     = PARTS_PER_BANK * DEF_PART_SIZE;
  localparam int unsigned ROWS_PER_PART  = 6;
  localparam int unsigned LOOP_DEEP      = 6;
  localparam int unsigned TRANSFER_TIMES = 3;
  localparam int unsigned BANKS_PER_RUN  = (LOOP_DEEP + 1) * (TRANSFER_TIMES + 1);
  localparam int unsigned WORD_W         = 10;
  localparam int unsigned BANK_CNT_W     = 5;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_CONFIG    = 5'b00010,
    ST_WAIT_BANK = 5'b00100,
    ST_READ      = 5'b01000,
    ST_DRAIN     = 5'b10000
  } state_e;

  // Row width W per layer; unknown layers produce no words.
  function automatic int unsigned layer_w(input logic [2:0] layer);
    int unsigned w;
    w = 0;
    case (layer)
      3'd1:    w = 119;
      3'd2:    w = 59;
      3'd3:    w = 29;
      3'd4:    w = 14;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] layer_words(input logic [2:0] layer);
    return WORD_W'(ROWS_PER_PART * layer_w(layer));
  endfunction

  function automatic int unsigned bank_base(input logic bank, input int unsigned part_size);
    return bank ? PARTS_PER_BANK * part_size : 0;
  endfunction

endpackage

// File: rtl/out_skid_fifo.sv
// Two-entry skid FIFO absorbing the BRAM read latency under downstream backpressure.
module out_skid_fifo #(
  parameter int unsigned W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              pop_eff;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pop_eff  = pop && (count_q != 2'd0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_eff) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/output_read.sv
// Drains completed ping/pong output banks from BRAM onto a 128-bit stream.
// Optional stall counter: define OUTPUT_READ_STALL_CNT_EN.
module output_read
  import output_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned PART_SIZE  = DEF_PART_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              layer,
  input  logic                    bank_done,
  input  logic                    bank_done_id,
  output logic                    en_rd,
  output logic [ADDR_WIDTH-1:0]   addr_rd,
  input  logic [DATA_WIDTH-1:0]   din_b0,
  input  logic [DATA_WIDTH-1:0]   din_b1,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    bank_free,
  output logic                    bank_free_id,
  output logic                    read_done,
  output logic                    err_overflow,
  output logic [31:0]             stall_cnt
);

  localparam int unsigned FIFO_W = 2 * DATA_WIDTH + 1;

  state_e                state_q, state_d;
  logic [2:0]            layer_q, layer_d;
  logic [WORD_W-1:0]     words_q, words_d;
  logic [BANK_CNT_W-1:0] banks_left_q, banks_left_d;
  logic [1:0]            pending_q, pending_d;
  logic                  exp_bank_q, exp_bank_d;
  logic [1:0]            part_q, part_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic                  inflight_q, inflight_d;
  logic                  last_inflight_q, last_inflight_d;
  logic                  err_q, err_d;
  logic                  bank_free_q, bank_free_d;
  logic                  bank_free_id_q, bank_free_id_d;
  logic                  read_done_q, read_done_d;

  logic                  en_rd_c;
  logic                  issue_last_c;
  logic                  pop_c;
  logic                  free_now_c;
  logic [2:0]            occ_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  fifo_valid;
  logic [FIFO_W-1:0]     fifo_out;
  logic [1:0]            fifo_count;
  logic                  fifo_last;

  assign fifo_last    = fifo_out[FIFO_W-1];
  assign pop_c        = fifo_valid && m_ready;
  assign free_now_c   = pop_c && fifo_last;
  assign issue_last_c = (part_q == 2'd3) && (word_q == words_q - WORD_W'(1));
  // Occupancy net of this cycle's pop: sustains 1 word/clk yet never overfills 2 entries.
  assign occ_c        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);
  assign addr_c       = ADDR_WIDTH'(bank_base(exp_bank_q, PART_SIZE)
                                    + 32'(part_q) * PART_SIZE + 32'(word_q));

  always_comb begin
    state_d         = state_q;
    layer_d         = layer_q;
    words_d         = words_q;
    banks_left_d    = banks_left_q;
    pending_d       = pending_q;
    exp_bank_d      = exp_bank_q;
    part_d          = part_q;
    word_d          = word_q;
    inflight_d      = 1'b0;
    last_inflight_d = 1'b0;
    err_d           = err_q;
    bank_free_d     = 1'b0;
    bank_free_id_d  = bank_free_id_q;
    read_done_d     = 1'b0;
    en_rd_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          layer_d = layer;
          state_d = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        words_d      = layer_words(layer_q);
        banks_left_d = BANK_CNT_W'(BANKS_PER_RUN);
        exp_bank_d   = 1'b0;
        part_d       = 2'd0;
        word_d       = '0;
        if (layer_words(layer_q) == '0) begin
          state_d     = ST_IDLE;
          read_done_d = 1'b1;
        end else begin
          state_d = ST_WAIT_BANK;
        end
      end
      ST_WAIT_BANK: begin
        if (pending_q[exp_bank_q]) begin
          part_d  = 2'd0;
          word_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (occ_c < 3'd2) begin
          en_rd_c         = 1'b1;
          inflight_d      = 1'b1;
          last_inflight_d = issue_last_c;
          if (issue_last_c) begin
            state_d = ST_DRAIN;
          end else if (word_q == words_q - WORD_W'(1)) begin
            word_d = '0;
            part_d = part_q + 2'd1;
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          if (banks_left_q == '0) begin
            state_d     = ST_IDLE;
            read_done_d = 1'b1;
          end else begin
            state_d = ST_WAIT_BANK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Final word of the bank accepted downstream: hand the bank back.
    if (free_now_c) begin
      bank_free_d           = 1'b1;
      bank_free_id_d        = exp_bank_q;
      pending_d[exp_bank_q] = 1'b0;
      banks_left_d          = banks_left_q - BANK_CNT_W'(1);
      exp_bank_d            = ~exp_bank_q;
    end

    // A re-completion in the same cycle the bank is freed is legal.
    if (bank_done) begin
      if (pending_q[bank_done_id] && !(free_now_c && (exp_bank_q == bank_done_id))) begin
        err_d = 1'b1;
      end
      pending_d[bank_done_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      layer_q         <= 3'd0;
      words_q         <= '0;
      banks_left_q    <= '0;
      pending_q       <= 2'b00;
      exp_bank_q      <= 1'b0;
      part_q          <= 2'd0;
      word_q          <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      err_q           <= 1'b0;
      bank_free_q     <= 1'b0;
      bank_free_id_q  <= 1'b0;
      read_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      layer_q         <= layer_d;
      words_q         <= words_d;
      banks_left_q    <= banks_left_d;
      pending_q       <= pending_d;
      exp_bank_q      <= exp_bank_d;
      part_q          <= part_d;
      word_q          <= word_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
      err_q           <= err_d;
      bank_free_q     <= bank_free_d;
      bank_free_id_q  <= bank_free_id_d;
      read_done_q     <= read_done_d;
    end
  end

  out_skid_fifo #(.W(FIFO_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({last_inflight_q, din_b1, din_b0}),
    .pop       (pop_c),
    .out_valid (fifo_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign en_rd        = en_rd_c;
  assign addr_rd      = en_rd_c ? addr_c : '0;
  assign m_valid      = fifo_valid;
  assign m_data       = fifo_out[2*DATA_WIDTH-1:0];
  assign m_last       = fifo_valid && fifo_last;
  assign bank_free    = bank_free_q;
  assign bank_free_id = bank_free_id_q;
  assign read_done    = read_done_q;
  assign err_overflow = err_q;

`ifdef OUTPUT_READ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Backpressure cycles, cleared on each run start and saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if (fifo_valid && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_output_read.sv
// Directed bench for output_read: bank ordering, addressing, backpressure, errors and reset.
module tb_output_read;
  import output_buf_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 13;
  localparam int unsigned PS = 1024;

  logic          clk = 1'b0;
  logic          rst, start, bank_done, bank_done_id;
  logic [2:0]    layer;
  logic          en_rd, m_valid, m_ready, m_last;
  logic          bank_free, bank_free_id, read_done, err_overflow;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] din_b0, din_b1;
  logic [2*DW-1:0] m_data;
  logic [31:0]   stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0]   addr_log[$];
  logic [2*DW-1:0] data_log[$];
  logic            last_log[$];
  logic            free_log[$];
  int              done_cnt, stab_err, max_cnt;
  logic            stalled_prev;
  logic [2*DW-1:0] data_prev;
  logic            last_prev;
  bit              ok;

  always #5 clk = ~clk;

  output_read dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer),
    .bank_done(bank_done), .bank_done_id(bank_done_id),
    .en_rd(en_rd), .addr_rd(addr_rd), .din_b0(din_b0), .din_b1(din_b1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .bank_free(bank_free), .bank_free_id(bank_free_id), .read_done(read_done),
    .err_overflow(err_overflow), .stall_cnt(stall_cnt)
  );

  function automatic logic [2*DW-1:0] mem_word(input logic [AW-1:0] a);
    return {32'hB1B1_0000, 19'd0, a, 32'hB0B0_0000, 19'd0, a};
  endfunction

  // BRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (en_rd) {din_b1, din_b0} <= mem_word(addr_rd);
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (en_rd) addr_log.push_back(addr_rd);
      if (m_valid && m_ready) begin
        data_log.push_back(m_data);
        last_log.push_back(m_last);
      end
      if (bank_free) free_log.push_back(bank_free_id);
      if (read_done) done_cnt++;
      if (stalled_prev && (!m_valid || m_data !== data_prev || m_last !== last_prev)) stab_err++;
      if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
    end
    stalled_prev = m_valid && !m_ready && !rst;
    data_prev    = m_data;
    last_prev    = m_last;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete(); data_log.delete(); last_log.delete(); free_log.delete();
    done_cnt = 0; stab_err = 0; max_cnt = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; bank_done = 1'b0; bank_done_id = 1'b0;
    layer = 3'd0; m_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_logs();
    tick(1);
  endtask

  task automatic do_start(input logic [2:0] l);
    layer = l; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_done(input logic id);
    bank_done = 1'b1; bank_done_id = id;
    tick(1);
    bank_done = 1'b0;
  endtask

  task automatic wait_free(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bank_free) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Compare the captured stream and read addresses against the expected bank/part/word order.
  task automatic chk_stream(input string tag, input int nb, input int words, input bit alt);
    int per, bad_d, bad_l, bad_a, b, j;
    logic [AW-1:0] a;
    per = 4 * words; bad_d = 0; bad_l = 0; bad_a = 0;
    chk({tag, "_word_count"}, 128'(data_log.size()), 128'(nb * per));
    chk({tag, "_addr_count"}, 128'(addr_log.size()), 128'(nb * per));
    for (int k = 0; k < nb * per && k < data_log.size(); k++) begin
      b = alt ? (k / per) % 2 : 0;
      j = k % per;
      a = AW'(b * 4 * PS + (j / words) * PS + j % words);
      if (data_log[k] !== mem_word(a)) bad_d++;
      if (last_log[k] !== (j == per - 1)) bad_l++;
      if (k < addr_log.size() && addr_log[k] !== a) bad_a++;
    end
    chk({tag, "_data_errs"}, 128'(bad_d), 128'(0));
    chk({tag, "_last_errs"}, 128'(bad_l), 128'(0));
    chk({tag, "_addr_errs"}, 128'(bad_a), 128'(0));
  endtask

  initial begin
    // Reset state
    rst = 1'b1; start = 1'b0; bank_done = 1'b0; bank_done_id = 1'b0;
    layer = 3'd0; m_ready = 1'b1;
    tick(3);
    chk("rst_en_rd", 128'(en_rd), 128'(0));
    chk("rst_addr_rd", 128'(addr_rd), 128'(0));
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_data", 128'(m_data), 128'(0));
    chk("rst_m_last", 128'(m_last), 128'(0));
    chk("rst_bank_free", 128'(bank_free), 128'(0));
    chk("rst_read_done", 128'(read_done), 128'(0));
    chk("rst_err", 128'(err_overflow), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));

    // Layer 4, one bank, latency and same-cycle re-completion on free
    reset_dut();
    do_start(3'd4);
    tick(2);
    bank_done = 1'b1; bank_done_id = 1'b0;
    tick(1);
    bank_done = 1'b0;
    chk("t1_en_rd_before_read", 128'(en_rd), 128'(0));
    tick(1);
    chk("t1_en_rd_first", 128'(en_rd), 128'(1));
    chk("t1_addr_first", 128'(addr_rd), 128'(0));
    tick(1);
    chk("t1_valid_lat1", 128'(m_valid), 128'(0));
    tick(1);
    chk("t1_valid_lat2", 128'(m_valid), 128'(1));
    chk("t1_first_data", 128'(m_data), 128'(mem_word(AW'(0))));
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (m_valid && m_last) begin
        ok = 1'b1;
        bank_done = 1'b1; bank_done_id = 1'b0;
        break;
      end
      tick(1);
    end
    chk("t1_last_seen", 128'(ok), 128'(1));
    tick(1);
    bank_done = 1'b0;
    chk("t1_bank_free", 128'(bank_free), 128'(1));
    chk("t1_bank_free_id", 128'(bank_free_id), 128'(0));
    tick(1);
    chk("t1_bank_free_pulse", 128'(bank_free), 128'(0));
    tick(2);
    chk("t1_err_same_cycle", 128'(err_overflow), 128'(0));
    chk_stream("t1", 1, 84, 1'b0);

    // Layer 3 with m_ready toggling every cycle
    reset_dut();
    do_start(3'd3);
    tick(2);
    pulse_done(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (free_log.size() != 0) break;
      m_ready = ~m_ready;
      tick(1);
    end
    m_ready = 1'b1;
    tick(2);
    chk("t2_free_count", 128'(free_log.size()), 128'(1));
    chk("t2_stability_errs", 128'(stab_err), 128'(0));
    chk("t2_fifo_max_le2", 128'(max_cnt <= 2), 128'(1));
    chk_stream("t2", 1, 174, 1'b0);

    // Full layer-4 run, bank 1 reported first
    reset_dut();
    do_start(3'd4);
    tick(2);
    pulse_done(1'b1);
    tick(20);
    chk("t3_no_read_before_b0", 128'(addr_log.size()), 128'(0));
    pulse_done(1'b0);
    ok = 1'b1;
    for (int k = 2; k < 28; k++) begin
      wait_free(2000, ok);
      if (!ok) break;
      bank_done = 1'b1; bank_done_id = bank_free_id;
      tick(1);
      bank_done = 1'b0;
    end
    chk("t3_free_timeout", 128'(ok), 128'(1));
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != 0) break;
      tick(1);
    end
    tick(3);
    chk("t3_free_pulses", 128'(free_log.size()), 128'(28));
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < free_log.size(); k++) if (free_log[k] !== 1'(k % 2)) bad++;
      chk("t3_free_alternation", 128'(bad), 128'(0));
    end
    chk("t3_read_done_once", 128'(done_cnt), 128'(1));
    chk("t3_err", 128'(err_overflow), 128'(0));
    chk("t3_idle", 128'(dut.state_q), 128'(ST_IDLE));
    chk_stream("t3", 28, 84, 1'b1);

    // Duplicate bank_done then reset mid-READ
    reset_dut();
    do_start(3'd4);
    tick(2);
    pulse_done(1'b0);
    tick(3);
    chk("t4_err_clear", 128'(err_overflow), 128'(0));
    pulse_done(1'b0);
    chk("t4_err_set", 128'(err_overflow), 128'(1));
    tick(5);
    chk("t4_err_sticky", 128'(err_overflow), 128'(1));
    chk("t4_in_read", 128'(dut.state_q), 128'(ST_READ));
    rst = 1'b1;
    tick(1);
    chk("t4_rst_en_rd", 128'(en_rd), 128'(0));
    chk("t4_rst_m_valid", 128'(m_valid), 128'(0));
    chk("t4_rst_bank_free", 128'(bank_free), 128'(0));
    chk("t4_rst_err", 128'(err_overflow), 128'(0));
    chk("t4_rst_idle", 128'(dut.state_q), 128'(ST_IDLE));
    rst = 1'b0;

    // Unknown layer: immediate read_done
    reset_dut();
    layer = 3'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t5_done_cycle1", 128'(read_done), 128'(0));
    tick(1);
    chk("t5_done_cycle2", 128'(read_done), 128'(1));
    tick(1);
    chk("t5_done_pulse", 128'(read_done), 128'(0));
    tick(3);
    chk("t5_no_en_rd", 128'(addr_log.size()), 128'(0));
    chk("t5_done_once", 128'(done_cnt), 128'(1));

    // Backpressure counter
    reset_dut();
    do_start(3'd4);
    tick(2);
    m_ready = 1'b0;
    pulse_done(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("t6_valid_seen", 128'(ok), 128'(1));
    tick(10);
`ifdef OUTPUT_READ_STALL_CNT_EN
    chk("t6_stall_cnt", 128'(stall_cnt), 128'(10));
`else
    chk("t6_stall_cnt_off", 128'(stall_cnt), 128'(0));
`endif
    chk("t6_held_valid", 128'(m_valid), 128'(1));
    chk("t6_held_data", 128'(m_data), 128'(mem_word(AW'(0))));
    m_ready = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
